// File: rtl/usi_pkg.sv
// usi_pkg: shared types and field positions for the USI UART transmitter.
// Holds the FSM state enum, parameters-word field layout and frame helpers.
package usi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int LEN_LSB     = 0;
   localparam int LEN_W       = 2;
   localparam int PAR_EN_BIT  = 2;
   localparam int PAR_ODD_BIT = 3;
   localparam int STOP2_BIT   = 4;
   localparam int CFG_W       = 5;

   // Index of the last data bit: 4..7 for 5..8 data bits.
   function automatic logic [2:0] last_bit(input logic [CFG_W-1:0] cfg);
      return 3'd4 + {1'b0, cfg[LEN_LSB +: LEN_W]};
   endfunction

   // Parity over the bits actually sent; inverted for odd parity.
   function automatic logic frame_parity(input logic [7:0]       data,
                                         input logic [CFG_W-1:0] cfg);
      logic [7:0] mask;
      mask = ~(8'hE0 << cfg[LEN_LSB +: LEN_W]);
      return (^(data & mask)) ^ cfg[PAR_ODD_BIT];
   endfunction

endpackage

// File: rtl/usi_baud_tick.sv
// usi_baud_tick: bit-period counter, counts 0..period-1 and wraps.
// Ports: CLK, RST (async high), clear (hold at 0), period, tick (count==period-1).
module usi_baud_tick (
   input  logic        CLK,
   input  logic        RST,
   input  logic        clear,
   input  logic [31:0] period,
   output logic        tick
);

   logic [31:0] count;

   assign tick = (count == period - 32'd1);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count <= '0;
      end else if (clear || tick) begin
         count <= '0;
      end else begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/usi_uart_tx.sv
// usi_uart_tx: single-frame UART transmitter with 5-8 data bits, optional parity, 1/2 stop.
// Ports: CLK, RST, start, tx_data, clkdiv, parameters in; tx, busy, done, error out.
module usi_uart_tx
   import usi_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic [31:0] tx_data,
   input  logic [31:0] clkdiv,
   input  logic [31:0] parameters,
   output logic        tx,
   output logic        busy,
   output logic        done,
   output logic        error
);

   state_t           state;
   logic [31:0]      div_q;
   logic [CFG_W-1:0] cfg_q;
   logic [7:0]       shreg;
   logic             par_q;
   logic [2:0]       bit_cnt;
   logic             stop2;
   logic             tick;
   logic             clear;
   logic             unused;

   assign unused = ^{tx_data[31:8], parameters[31:CFG_W]};

   // Counter idles at zero so the first bit period starts cleanly.
   assign clear = (state == IDLE);

   usi_baud_tick u_baud (
      .CLK    (CLK),
      .RST    (RST),
      .clear  (clear),
      .period (div_q),
      .tick   (tick)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         tx      <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
         div_q   <= '0;
         cfg_q   <= '0;
         shreg   <= '0;
         par_q   <= 1'b0;
         bit_cnt <= '0;
         stop2   <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               if (clkdiv == 32'd0) begin
                  error <= 1'b1;
               end else begin
                  div_q <= clkdiv;
                  cfg_q <= parameters[CFG_W-1:0];
                  shreg <= tx_data[7:0];
                  par_q <= frame_parity(tx_data[7:0],
                                        parameters[CFG_W-1:0]);
                  state <= START;
                  tx    <= 1'b0;
                  busy  <= 1'b1;
               end
            end
         end else begin
            // Requests during a frame are rejected, frame continues.
            error <= start;
            if (tick) begin
               case (state)
                  START: begin
                     state   <= DATA;
                     tx      <= shreg[0];
                     bit_cnt <= '0;
                  end
                  DATA: begin
                     if (bit_cnt == last_bit(cfg_q)) begin
                        stop2 <= 1'b0;
                        if (cfg_q[PAR_EN_BIT]) begin
                           state <= PARITY;
                           tx    <= par_q;
                        end else begin
                           state <= STOP;
                           tx    <= 1'b1;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shreg   <= shreg >> 1;
                        tx      <= shreg[1];
                     end
                  end
                  PARITY: begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end
                  STOP: begin
                     if (cfg_q[STOP2_BIT] && !stop2) begin
                        stop2 <= 1'b1;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule
